// File: rtl/mux_n_scan.sv
// Registered NCH-way, WIDTH-bit channel mux with manual select or dwell-timed scan.
// 1-cycle latency from sampled inputs; no backpressure, en gates every sample/advance.
module mux_n_scan #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] in_bus,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 en,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int              DWW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int              NSLOT   = 2 ** SELW;
    localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NCH);
    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
    localparam logic [DWW-1:0]  LAST_DW = DWW'(DWELL - 1);

    // Pad the channel table to the full select range so any sel indexes a real entry.
    logic [WIDTH-1:0] chan [NSLOT];

    for (genvar k = 0; k < NSLOT; k++) begin : g_chan
        if (k < NCH) begin : g_real
            assign chan[k] = in_bus[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             scan_wrap_q, scan_wrap_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic [DWW-1:0]   dw_q, dw_d;
    logic             mode_q, mode_d;

    logic             entry;
    logic [SELW-1:0]  eff_ch;
    logic [DWW-1:0]   eff_dw;

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        scan_wrap_d = 1'b0;
        ch_d        = ch_q;
        dw_d        = dw_q;
        mode_d      = mode;

        // A scan entry restarts at channel 0 only when it coincides with an enabled cycle.
        entry  = mode && !mode_q;
        eff_ch = entry ? '0 : ch_q;
        eff_dw = entry ? '0 : dw_q;

        if (en) begin
            if (!mode) begin
                out_ch_d = sel;
                if ({1'b0, sel} < NCH_W) begin
                    out_d       = chan[sel];
                    out_valid_d = 1'b1;
                end else begin
                    out_d = '0;
                end
            end else begin
                out_d       = chan[eff_ch];
                out_ch_d    = eff_ch;
                out_valid_d = 1'b1;
                if (eff_dw == LAST_DW) begin
                    dw_d = '0;
                    if (eff_ch == LAST_CH) begin
                        ch_d        = '0;
                        scan_wrap_d = 1'b1;
                    end else begin
                        ch_d = eff_ch + SELW'(1);
                    end
                end else begin
                    dw_d = eff_dw + DWW'(1);
                    ch_d = eff_ch;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            scan_wrap_q <= 1'b0;
            ch_q        <= '0;
            dw_q        <= '0;
            mode_q      <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            scan_wrap_q <= scan_wrap_d;
            ch_q        <= ch_d;
            dw_q        <= dw_d;
            mode_q      <= mode_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign scan_wrap = scan_wrap_q;

endmodule
